// File: rtl/avalon_shell_pipe.sv
// Purpose : buffered Avalon-MM shell; design commands go through a command FIFO to a registered Qsys master port.
// Latency : a command accepted in cycle N reaches avm_m0_* in N+2; read data returns 2 cycles after the Qsys completion.
// Backpr. : design waitrequest follows FIFO full; reads block until data returns; avm_m0_waitrequest holds the output register.
// Ports   : clk/reset (sync, active-high); avm_design_* slave-facing command port; avm_m0_* Qsys master port;
//           pending_count (queued + in-flight), idle, protocol_err (sticky read&write collision).
module avalon_shell_pipe #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             avm_design_address,
  input  logic                          avm_design_read,
  input  logic                          avm_design_write,
  input  logic [DATA_W-1:0]             avm_design_writedata,
  output logic                          avm_design_waitrequest,
  output logic [DATA_W-1:0]             avm_design_readdata,
  output logic [ADDR_W-1:0]             avm_m0_address,
  output logic                          avm_m0_read,
  output logic                          avm_m0_write,
  output logic [DATA_W-1:0]             avm_m0_writedata,
  input  logic                          avm_m0_waitrequest,
  input  logic [DATA_W-1:0]             avm_m0_readdata,
  output logic [$clog2(FIFO_DEPTH):0]   pending_count,
  output logic                          idle,
  output logic                          protocol_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

  state_t            state, state_nxt;
  entry_t            fifo_mem [FIFO_DEPTH];
  entry_t            push_entry;
  entry_t            head;
  logic [PTR_W:0]    wr_ptr, rd_ptr, fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              push, pop, load;
  logic              cmd_active, rd_cmpl, rd_cmpl_q;
  logic [DATA_W-1:0] rdata_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  // The output register takes a new command when it holds none or the current one completes.
  assign cmd_active = avm_m0_read | avm_m0_write;
  assign load       = !cmd_active || !avm_m0_waitrequest;
  assign pop        = load && !fifo_empty;
  assign rd_cmpl    = avm_m0_read && !avm_m0_waitrequest;

  assign pending_count = fifo_cnt + {{PTR_W{1'b0}}, cmd_active};
  assign idle          = fifo_empty && !cmd_active && (state == IDLE);

  always_comb begin
    state_nxt              = state;
    push                   = 1'b0;
    push_entry             = {avm_design_read, avm_design_address, avm_design_writedata};
    avm_design_waitrequest = 1'b1;
    avm_design_readdata    = '0;
    case (state)
      IDLE: begin
        avm_design_waitrequest = fifo_full;
        // A read wins over a simultaneous write; the write is dropped.
        if (!fifo_full && avm_design_read) begin
          push                   = 1'b1;
          avm_design_waitrequest = 1'b1;
          state_nxt              = RD_WAIT;
        end else if (!fifo_full && avm_design_write) begin
          push                   = 1'b1;
          avm_design_waitrequest = 1'b0;
        end
      end
      // Completion is taken from a registered flag so the design-side FSM
      // never sees avm_m0_waitrequest combinationally.
      RD_WAIT: begin
        if (rd_cmpl_q) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        avm_design_waitrequest = 1'b0;
        avm_design_readdata    = rdata_q;
        state_nxt              = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) avm_design_waitrequest = 1'b1;
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      avm_m0_address   <= '0;
      avm_m0_read      <= 1'b0;
      avm_m0_write     <= 1'b0;
      avm_m0_writedata <= '0;
      rd_cmpl_q        <= 1'b0;
      rdata_q          <= '0;
      protocol_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (load) begin
        if (!fifo_empty) begin
          avm_m0_address   <= head.addr;
          avm_m0_writedata <= head.wdata;
          avm_m0_read      <= head.is_read;
          avm_m0_write     <= !head.is_read;
        end else begin
          avm_m0_read  <= 1'b0;
          avm_m0_write <= 1'b0;
        end
      end
      rd_cmpl_q <= rd_cmpl;
      if (rd_cmpl) rdata_q <= avm_m0_readdata;
      if (state == IDLE && avm_design_read && avm_design_write) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_shell_pipe.sv
// Purpose : self-checking bench for avalon_shell_pipe (directed table, corner sequences, random traffic).
// Latency : n/a (testbench).
// Backpr. : a Qsys slave model drives forced or random waitrequest; the design-side master holds commands until accepted.
module tb_avalon_shell_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read, write;
  logic [7:0]  writedata;
  logic        waitreq;
  logic [7:0]  readdata;
  logic [31:0] m0_address;
  logic        m0_read, m0_write;
  logic [7:0]  m0_writedata;
  logic        m0_waitrequest;
  logic [7:0]  m0_readdata;
  logic [2:0]  pending_count;
  logic        idle, protocol_err;

  logic force_wait, rand_en, rand_wait;
  int   n_tests = 0;
  int   n_fail  = 0;

  avalon_shell_pipe #(.ADDR_W(32), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .avm_design_address     (address),
    .avm_design_read        (read),
    .avm_design_write       (write),
    .avm_design_writedata   (writedata),
    .avm_design_waitrequest (waitreq),
    .avm_design_readdata    (readdata),
    .avm_m0_address         (m0_address),
    .avm_m0_read            (m0_read),
    .avm_m0_write           (m0_write),
    .avm_m0_writedata       (m0_writedata),
    .avm_m0_waitrequest     (m0_waitrequest),
    .avm_m0_readdata        (m0_readdata),
    .pending_count          (pending_count),
    .idle                   (idle),
    .protocol_err           (protocol_err)
  );

  always #5 clk = ~clk;

  // Qsys slave model: byte memory, forced or random stalls.
  bit [7:0]    slave_mem [256];
  logic [40:0] got_q[$];
  int          viol = 0;
  logic        prev_stall = 1'b0;
  logic [41:0] prev_out;

  assign m0_waitrequest = rand_en ? rand_wait : force_wait;
  assign m0_readdata    = slave_mem[m0_address[7:0]];

  always @(posedge clk) begin
    #1 rand_wait = ($urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (m0_read && m0_write) viol++;
      if (prev_stall && ({m0_read, m0_write, m0_address, m0_writedata} != prev_out)) viol++;
      if ((m0_read || m0_write) && !m0_waitrequest) begin
        got_q.push_back({m0_read, m0_address, m0_read ? 8'h00 : m0_writedata});
        if (m0_write) slave_mem[m0_address[7:0]] = m0_writedata;
      end
      prev_stall = (m0_read || m0_write) && m0_waitrequest;
      prev_out   = {m0_read, m0_write, m0_address, m0_writedata};
    end
  end

  // Reference: the shell is in-order, so a read returns the last accepted write to that address.
  bit [7:0]    ref_mem [256];
  logic [40:0] exp_q[$];

  typedef struct {
    bit          rd;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic master(input bit rd, input bit wr, input logic [31:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output int waits);
    read = rd; write = wr; address = a; writedata = d;
    waits = 0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!waitreq) begin
        rdata = readdata;
        break;
      end
      waits++;
      if (waits > 400) begin
        n_tests++; n_fail++;
        $display("FAIL master_timeout: addr 0x%0h still waiting after %0d cycles", a, waits);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] d, output int waits);
    logic [7:0] unused;
    master(1'b0, 1'b1, a, d, unused, waits);
    ref_mem[a[7:0]] = d;
    exp_q.push_back({1'b0, a, d});
  endtask

  task automatic do_read(input logic [31:0] a, output logic [7:0] rdata, output int waits);
    master(1'b1, 1'b0, a, 8'h00, rdata, waits);
    exp_q.push_back({1'b1, a, 8'h00});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!idle && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!idle) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: idle=%0b pending=%0d", idle, pending_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rd;
    int          w;
    logic [31:0] ea;
    logic [7:0]  ed;

    tbl[0] = '{1'b0, 32'h20, 8'h55, 8'h00};
    tbl[1] = '{1'b1, 32'h20, 8'h00, 8'h55};
    tbl[2] = '{1'b0, 32'h21, 8'h3C, 8'h00};
    tbl[3] = '{1'b0, 32'h22, 8'hC3, 8'h00};
    tbl[4] = '{1'b1, 32'h21, 8'h00, 8'h3C};
    tbl[5] = '{1'b1, 32'h22, 8'h00, 8'hC3};
    tbl[6] = '{1'b0, 32'h20, 8'h00, 8'h00};
    tbl[7] = '{1'b1, 32'h20, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 32'hFF, 8'hFF, 8'h00};
    tbl[9] = '{1'b1, 32'hFF, 8'h00, 8'hFF};

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    force_wait = 1'b0; rand_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", waitreq, 1);
    check("rst_idle", idle, 1);
    check("rst_pending", pending_count, 0);
    check("rst_m0", {m0_read, m0_write, m0_address, m0_writedata}, 0);
    check("rst_readdata", readdata, 0);
    check("rst_perr", protocol_err, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 3 posted writes, unstalled: m0_write on cycles 2..4, in order.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        write = 1'b1; address = 32'(16 + i); writedata = 8'(8'hA1 + i);
      end else begin
        write = 1'b0;
      end
      @(negedge clk);
      if (i < 3) check("t1_waitreq", waitreq, 0);
      check("t1_m0_write", m0_write, (i >= 2 && i < 5));
      if (i >= 2 && i < 5) begin
        ea = 32'(16 + i - 2); ed = 8'(8'hA1 + i - 2);
        check("t1_m0_addr_data", {m0_address, m0_writedata}, {ea, ed});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      ref_mem[16 + i] = 8'(8'hA1 + i);
      exp_q.push_back({1'b0, 32'(16 + i), 8'(8'hA1 + i)});
    end
    wait_idle();

    // Stalled Qsys: 5 writes fill 4 queued + 1 in flight, 6th waits.
    force_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_write(32'(32'h60 + i), 8'(8'hB0 + i), w);
      check("t2_accept", w, 0);
    end
    fork
      do_write(32'h65, 8'hB5, w);
      begin
        @(negedge clk);
        check("t2_pending_full", pending_count, 5);
        check("t2_waitreq_full", waitreq, 1);
        repeat (14) @(posedge clk);
        #1 force_wait = 1'b0;
      end
    join
    check("t2_sixth_waits", w, 15);
    wait_idle();

    // Directed table: write/read ordering and read latency on an unstalled bus.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rd) begin
        do_read(tbl[i].a, rd, w);
        check("t3_rdata", rd, tbl[i].exp);
        check("t3_rd_latency", w, 4);
      end else begin
        do_write(tbl[i].a, tbl[i].d, w);
        check("t3_wr_posted", w, 0);
      end
    end
    wait_idle();

    // Read with Qsys stalled 7 cycles: done 2 cycles after completion.
    force_wait = 1'b1;
    fork
      do_read(32'h21, rd, w);
      begin
        repeat (7) @(posedge clk);
        #1 force_wait = 1'b0;
      end
    join
    check("t4_rd_wait_cycles", w, 9);
    check("t4_rdata", rd, ref_mem[8'h21]);
    @(negedge clk);
    check("t4_idle_after", idle, 1);
    @(posedge clk); #1;

    // Read and write together: read only, sticky error.
    master(1'b1, 1'b1, 32'h30, 8'h99, rd, w);
    exp_q.push_back({1'b1, 32'h30, 8'h00});
    check("t5_rdata_write_dropped", rd, ref_mem[8'h30]);
    check("t5_latency", w, 4);
    @(negedge clk);
    check("t5_perr", protocol_err, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_perr_sticky", protocol_err, 1);
    @(posedge clk); #1;
    wait_idle();

    // Reset with 3 queued + 1 in flight; these writes are abandoned.
    force_wait = 1'b1;
    for (int i = 0; i < 4; i++) master(1'b0, 1'b1, 32'(32'h50 + i), 8'(8'hC0 + i), rd, w);
    @(negedge clk);
    check("t6_pending_before", pending_count, 4);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t6_waitreq_in_reset", waitreq, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_m0_cleared", {m0_read, m0_write}, 0);
    check("t6_pending", pending_count, 0);
    check("t6_idle", idle, 1);
    check("t6_perr_cleared", protocol_err, 0);
    @(posedge clk); #1;
    force_wait = 1'b0;
    do_write(32'h40, 8'h77, w);
    check("t6_write_after", w, 0);
    wait_idle();
    check("t6_slave_got_write", slave_mem[8'h40], 8'h77);

    // Random traffic against the last-written-value model.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ea = 32'($urandom_range(0, 15));
      ed = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        do_read(ea, rd, w);
        check("rand_rdata", rd, ref_mem[ea[7:0]]);
      end else begin
        do_write(ea, ed, w);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_en = 1'b0;
    wait_idle();

    check("sb_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("sb_order", got_q[i], exp_q[i]);
    check("qsys_protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
